// File: rtl/apb_gpio_irq.sv
// APB3/APB4 GPIO slave: configurable width, pin synchroniser, per-pin
// edge/level interrupt detection with sticky W1C status and atomic output toggle.
module apb_gpio_irq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRST_N,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [11:0]      PADDR,
  input  logic [31:0]      PWDATA,
  input  logic [3:0]       PSTRB,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] GpioIn,
  output logic [WIDTH-1:0] GpioOut,
  output logic [WIDTH-1:0] GpioOEn,
  output logic             irq
);

  localparam int unsigned BUS_W   = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic [SEL_W-1:0] {
    REG_DATA_IN    = 3'd0,
    REG_DATA_OUT   = 3'd1,
    REG_OEN        = 3'd2,
    REG_IRQ_EN     = 3'd3,
    REG_IRQ_TYPE   = 3'd4,
    REG_IRQ_POL    = 3'd5,
    REG_IRQ_STATUS = 3'd6,
    REG_OUT_TOGGLE = 3'd7
  } reg_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] oen_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_type_q;
  logic [WIDTH-1:0] irq_pol_q;
  logic [WIDTH-1:0] status_q;
  logic             irq_q;

  logic             access_c;
  logic             err_c;
  logic             wr_c;
  reg_e             sel_c;
  logic [BUS_W-1:0] lane_mask_c;
  logic [WIDTH-1:0] wmask_c;
  logic [WIDTH-1:0] wbits_c;
  logic [WIDTH-1:0] din_c;
  logic [WIDTH-1:0] edge_evt_c;
  logic [WIDTH-1:0] lvl_evt_c;
  logic [WIDTH-1:0] clr_c;
  logic [WIDTH-1:0] status_nxt_c;
  logic [BUS_W-1:0] rdata_c;
  logic             unused_c;

  assign unused_c = ^PADDR[1:0];

  // Access decode and error detection
  assign access_c = PSEL & PENABLE;
  assign sel_c    = reg_e'(PADDR[4:2]);
  assign err_c    = access_c & ((PADDR[11:5] != 7'd0) | (PWRITE & (sel_c == REG_DATA_IN)));
  assign wr_c     = access_c & PWRITE & ~err_c;

  always_comb begin
    lane_mask_c = '0;
    for (int n = 0; n < LANES; n++) begin
      lane_mask_c[8*n +: 8] = {8{PSTRB[n]}};
    end
  end

  assign wmask_c = WIDTH'(lane_mask_c);
  assign wbits_c = WIDTH'(PWDATA) & wmask_c;

  // Pin synchroniser; din_c is the DATA_IN register view
  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= GpioIn;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign din_c = sync_q[SYNC_STAGES-1];

  // Edge events override a same-cycle clear; level events re-assert one cycle after a clear
  assign edge_evt_c   = irq_type_q & ((irq_pol_q & din_c & ~prev_q) | (~irq_pol_q & ~din_c & prev_q));
  assign lvl_evt_c    = ~irq_type_q & ~(din_c ^ irq_pol_q);
  assign clr_c        = (wr_c && (sel_c == REG_IRQ_STATUS)) ? wbits_c : '0;
  assign status_nxt_c = (status_q & ~clr_c) | edge_evt_c | (lvl_evt_c & ~clr_c);

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      prev_q     <= '0;
      data_out_q <= '0;
      oen_q      <= '0;
      irq_en_q   <= '0;
      irq_type_q <= '0;
      irq_pol_q  <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q   <= din_c;
      status_q <= status_nxt_c;
      irq_q    <= |(status_q & irq_en_q);
      if (wr_c) begin
        case (sel_c)
          REG_DATA_OUT:   data_out_q <= (data_out_q & ~wmask_c) | wbits_c;
          REG_OEN:        oen_q      <= (oen_q & ~wmask_c) | wbits_c;
          REG_IRQ_EN:     irq_en_q   <= (irq_en_q & ~wmask_c) | wbits_c;
          REG_IRQ_TYPE:   irq_type_q <= (irq_type_q & ~wmask_c) | wbits_c;
          REG_IRQ_POL:    irq_pol_q  <= (irq_pol_q & ~wmask_c) | wbits_c;
          REG_OUT_TOGGLE: data_out_q <= data_out_q ^ wbits_c;
          default:        ;
        endcase
      end
    end
  end

  // Read mux; errored reads and non-read phases return 0
  always_comb begin
    rdata_c = '0;
    if (access_c && !PWRITE && !err_c) begin
      case (sel_c)
        REG_DATA_IN:    rdata_c = BUS_W'(din_c);
        REG_DATA_OUT:   rdata_c = BUS_W'(data_out_q);
        REG_OEN:        rdata_c = BUS_W'(oen_q);
        REG_IRQ_EN:     rdata_c = BUS_W'(irq_en_q);
        REG_IRQ_TYPE:   rdata_c = BUS_W'(irq_type_q);
        REG_IRQ_POL:    rdata_c = BUS_W'(irq_pol_q);
        REG_IRQ_STATUS: rdata_c = BUS_W'(status_q);
        default:        rdata_c = '0;
      endcase
    end
  end

  assign PRDATA  = rdata_c;
  assign PREADY  = 1'b1;
  assign PSLVERR = err_c;
  assign GpioOut = data_out_q;
  assign GpioOEn = oen_q;
  assign irq     = irq_q;

endmodule
